schmidl_cox_frame_ctrl: RTL

//  Frame sequencer downstream of the Schmidl-Cox peak finder. Consumes the sample stream in

---
 rtl/schmidl_cox_pkg.sv | 19 +
 rtl/schmidl_cox_frame_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/schmidl_cox_pkg.sv
// schmidl_cox_pkg: shared types and detector field positions for the Schmidl-Cox frame controller
package schmidl_cox_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ALIGN,
        ST_CP,
        ST_SYM,
        ST_HOLDOFF
    } frame_state_t;

    typedef logic [15:0] cnt_t;

    localparam int DET_PHASE_MSB  = 31;
    localparam int DET_PHASE_LSB  = 16;
    localparam int DET_OFFSET_MSB = 15;
    localparam int DET_OFFSET_LSB = 0;

endpackage

// File: rtl/schmidl_cox_frame_ctrl.sv
// schmidl_cox_frame_ctrl: aligns to a detected burst, strips cyclic prefixes, streams FFT symbols (optional stats: SCHMIDL_COX_FRAME_STATS_EN)
module schmidl_cox_frame_ctrl
    import schmidl_cox_pkg::*;
#(
    parameter int FFT_SIZE    = 64,
    parameter int CP_LEN      = 16,
    parameter int NUM_SYMBOLS = 10,
    parameter int START_DELAY = 160,
    parameter int HOLDOFF     = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic [31:0] i_tdata,
    input  logic        i_tvalid,
    output logic        i_tready,
    input  logic [31:0] det_tdata,
    input  logic        det_tlast,
    input  logic        det_tvalid,
    output logic        det_tready,
    output logic [31:0] o_tdata,
    output logic [15:0] o_tuser,
    output logic        o_tlast,
    output logic        o_tvalid,
    input  logic        o_tready,
`ifdef SCHMIDL_COX_FRAME_STATS_EN
    output logic [31:0] frame_cnt,
    output logic [31:0] drop_cnt,
`endif
    output logic        busy,
    output logic        late_drop
);

    frame_state_t state_q, state_d;
    cnt_t         cnt_q, cnt_d;
    cnt_t         sym_q, sym_d;
    logic [15:0]  phase_q, phase_d;
    logic         late_q, late_d;
    logic         beat;
    cnt_t         off;
    cnt_t         skip;

    assign beat       = i_tvalid & det_tvalid & ((state_q != ST_SYM) | o_tready);
    assign i_tready   = beat;
    assign det_tready = beat;
    assign off        = det_tdata[DET_OFFSET_MSB:DET_OFFSET_LSB];
    assign skip       = cnt_t'(START_DELAY) - off - 16'd1;
    assign o_tdata    = i_tdata;
    assign o_tvalid   = (state_q == ST_SYM) & i_tvalid & det_tvalid;
    assign o_tlast    = (state_q == ST_SYM) & (cnt_q == cnt_t'(FFT_SIZE - 1));
    assign o_tuser    = phase_q;
    assign busy       = state_q != ST_IDLE;
    assign late_drop  = late_q;

    // next state: the shared counter counts down through ALIGN and up through CP/SYM/HOLDOFF
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sym_d   = sym_q;
        phase_d = phase_q;
        late_d  = 1'b0;
        if (beat) begin
            case (state_q)
                ST_IDLE: begin
                    if (det_tlast) begin
                        phase_d = det_tdata[DET_PHASE_MSB:DET_PHASE_LSB];
                        if (off >= cnt_t'(START_DELAY)) begin
                            late_d = 1'b1;
                        end else if (skip == '0) begin
                            state_d = ST_CP;
                            cnt_d   = '0;
                        end else begin
                            state_d = ST_ALIGN;
                            cnt_d   = skip;
                        end
                    end
                end
                ST_ALIGN: begin
                    state_d = (cnt_q == 16'd1) ? ST_CP : ST_ALIGN;
                    cnt_d   = (cnt_q == 16'd1) ? '0 : cnt_q - 16'd1;
                end
                ST_CP: begin
                    state_d = (cnt_q == cnt_t'(CP_LEN - 1)) ? ST_SYM : ST_CP;
                    cnt_d   = (cnt_q == cnt_t'(CP_LEN - 1)) ? '0 : cnt_q + 16'd1;
                end
                ST_SYM: begin
                    if (cnt_q == cnt_t'(FFT_SIZE - 1)) begin
                        cnt_d   = '0;
                        state_d = (sym_q == cnt_t'(NUM_SYMBOLS - 1)) ? ST_HOLDOFF : ST_CP;
                        sym_d   = (sym_q == cnt_t'(NUM_SYMBOLS - 1)) ? '0 : sym_q + 16'd1;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                ST_HOLDOFF: begin
                    state_d = (cnt_q == cnt_t'(HOLDOFF - 1)) ? ST_IDLE : ST_HOLDOFF;
                    cnt_d   = (cnt_q == cnt_t'(HOLDOFF - 1)) ? '0 : cnt_q + 16'd1;
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // state registers with synchronous reset or soft clear
    always_ff @(posedge clk) begin
        if (reset | clear) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sym_q   <= '0;
            phase_q <= '0;
            late_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sym_q   <= sym_d;
            phase_q <= phase_d;
            late_q  <= late_d;
        end
    end

`ifdef SCHMIDL_COX_FRAME_STATS_EN
    logic [31:0] frame_q;
    logic [31:0] drop_q;
    logic        frame_end;

    assign frame_end = beat & (state_q == ST_SYM) & (state_d == ST_HOLDOFF);
    assign frame_cnt = frame_q;
    assign drop_cnt  = drop_q;

    // saturating frame and late-drop counters
    always_ff @(posedge clk) begin
        if (reset | clear) begin
            frame_q <= '0;
            drop_q  <= '0;
        end else begin
            if (frame_end && !(&frame_q)) frame_q <= frame_q + 32'd1;
            if (late_d && !(&drop_q)) drop_q <= drop_q + 32'd1;
        end
    end
`endif

endmodule
